// File: rtl/accel_csr_slave.sv
`default_nettype none
// ============================================================================
// Module      : accel_csr_slave
// Description : AXI4-Lite register file that programs the dot-product core
//               (CTRL, SRC_A, SRC_B, LEN, DST) and reports its STATUS.
//               Optional feature macro: ACCEL_CSR_IRQ_EN adds a level irq
//               output and makes CTRL.IE writable.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_csr_slave #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [ADDR_W-1:0] S_AWADDR,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  input  logic [31:0]       S_WDATA,
  input  logic [3:0]        S_WSTRB,
  output logic              S_BVALID,
  output logic [1:0]        S_BRESP,
  input  logic              S_BREADY,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  input  logic [ADDR_W-1:0] S_ARADDR,
  output logic              S_RVALID,
  output logic [31:0]       S_RDATA,
  output logic [1:0]        S_RRESP,
  input  logic              S_RREADY,
  output logic [31:0]       REG0,
  output logic [31:0]       REG1,
  output logic [31:0]       REG2,
  output logic [31:0]       REG3,
  output logic [31:0]       REG4,
  output logic [31:0]       REG5,
`ifdef ACCEL_CSR_IRQ_EN
  output logic              irq,
`endif
  input  logic              set_busy,
  input  logic              set_done,
  input  logic              set_error
);

  localparam int                  c_WORD_W    = ADDR_W - 2;
  localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(5);
  localparam logic [1:0]          c_OKAY      = 2'b00;
  localparam logic [1:0]          c_SLVERR    = 2'b10;

  // write channel state
  logic                r_aw_full, r_w_full, r_awready, r_wready, r_bvalid;
  logic [c_WORD_W-1:0] r_aw_word;
  logic [31:0]         r_w_data;
  logic [3:0]          r_w_strb;
  logic [1:0]          r_bresp;
  // read channel state
  logic                r_arready, r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  // register file
  logic                r_start, r_busy, r_done, r_error;
  logic [31:0]         r_src_a, r_src_b, r_dst;
  logic [LEN_W-1:0]    r_len;
  logic                w_ie;

  logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                w_aw_full_nxt, w_w_full_nxt;
  logic                w_commit, w_wr_err, w_wr_en;
  logic [2:0]          w_wr_idx;
  logic [31:0]         w_wmask;
  logic                w_start_nxt, w_busy_nxt, w_done_nxt, w_error_nxt;
  logic [31:0]         w_src_a_nxt, w_src_b_nxt, w_dst_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [c_WORD_W-1:0] w_ar_word;
  logic                w_rd_ok;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  // byte-lane merge of write data into an existing register value
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // address bits [1:0] never select anything
  assign w_unused = &{1'b0, S_AWADDR[1:0], S_ARADDR[1:0]};

  assign w_aw_hs = S_AWVALID & r_awready;
  assign w_w_hs  = S_WVALID & r_wready;
  assign w_b_hs  = r_bvalid & S_BREADY;
  assign w_ar_hs = S_ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & S_RREADY;

  // both buffers stay occupied until the response has been taken
  assign w_aw_full_nxt = w_b_hs ? 1'b0 : (r_aw_full | w_aw_hs);
  assign w_w_full_nxt  = w_b_hs ? 1'b0 : (r_w_full | w_w_hs);

  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;
  assign w_wr_idx = r_aw_word[2:0];
  assign w_wr_err = (r_aw_word > c_LAST_WORD) ||
                    (r_busy && (w_wr_idx >= 3'd1) && (w_wr_idx <= 3'd4));
  assign w_wr_en  = w_commit & ~w_wr_err;
  assign w_wmask  = {{8{r_w_strb[3]}}, {8{r_w_strb[2]}},
                     {8{r_w_strb[1]}}, {8{r_w_strb[0]}}};

`ifdef ACCEL_CSR_IRQ_EN
  logic r_ie;
  logic w_ie_nxt;
  assign w_ie = r_ie;
`else
  assign w_ie = 1'b0;
`endif

  assign REG0 = {30'h0, w_ie, r_start};
  assign REG1 = r_src_a;
  assign REG2 = r_src_b;
  assign REG3 = 32'(r_len);
  assign REG4 = r_dst;
  assign REG5 = {29'h0, r_error, r_done, r_busy};

  // next register values: host write first, then core status pulses on top
  always_comb begin
    w_start_nxt = r_start;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;
    w_src_a_nxt = r_src_a;
    w_src_b_nxt = r_src_b;
    w_len_nxt   = r_len;
    w_dst_nxt   = r_dst;
`ifdef ACCEL_CSR_IRQ_EN
    w_ie_nxt    = r_ie;
`endif
    if (w_wr_en) begin
      case (w_wr_idx)
        3'd0: begin
          if (r_w_strb[0]) begin
            if (!r_busy) w_start_nxt = r_w_data[0];
`ifdef ACCEL_CSR_IRQ_EN
            w_ie_nxt = r_w_data[1];
`endif
          end
        end
        3'd1: w_src_a_nxt = f_merge(r_src_a, r_w_data, w_wmask);
        3'd2: w_src_b_nxt = f_merge(r_src_b, r_w_data, w_wmask);
        3'd3: w_len_nxt   = LEN_W'(f_merge(32'(r_len), r_w_data, w_wmask));
        3'd4: w_dst_nxt   = f_merge(r_dst, r_w_data, w_wmask);
        3'd5: begin
          if (r_w_strb[0]) begin
            if (r_w_data[1]) w_done_nxt  = 1'b0;
            if (r_w_data[2]) w_error_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (set_busy) begin
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b0;
      w_start_nxt = 1'b0;
    end else if (set_done) begin
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b1;
    end else if (set_error) begin
      w_busy_nxt  = 1'b0;
      w_error_nxt = 1'b1;
      w_start_nxt = 1'b0;
    end
  end

  // read mux over the current (pre-commit) register values
  always_comb begin
    w_ar_word = S_ARADDR[ADDR_W-1:2];
    w_rd_ok   = (w_ar_word <= c_LAST_WORD);
    w_rd_data = 32'h0;
    if (w_rd_ok) begin
      case (w_ar_word[2:0])
        3'd0:    w_rd_data = REG0;
        3'd1:    w_rd_data = REG1;
        3'd2:    w_rd_data = REG2;
        3'd3:    w_rd_data = REG3;
        3'd4:    w_rd_data = REG4;
        3'd5:    w_rd_data = REG5;
        default: w_rd_data = 32'h0;
      endcase
    end
  end

  // write channel: AW/W buffers, ready flags and B response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_word <= '0;
      r_w_data  <= 32'h0;
      r_w_strb  <= 4'h0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_awready <= ~w_aw_full_nxt;
      r_wready  <= ~w_w_full_nxt;
      if (w_aw_hs) r_aw_word <= S_AWADDR[ADDR_W-1:2];
      if (w_w_hs) begin
        r_w_data <= S_WDATA;
        r_w_strb <= S_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? c_SLVERR : c_OKAY;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // read channel: one outstanding read, response held until taken
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= c_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rdata   <= w_rd_data;
        r_rresp   <= w_rd_ok ? c_OKAY : c_SLVERR;
      end else if (w_r_hs) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end else begin
        r_arready <= ~r_rvalid;
      end
    end
  end

  // register file update
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_src_a <= 32'h0;
      r_src_b <= 32'h0;
      r_len   <= '0;
      r_dst   <= 32'h0;
    end else begin
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_src_a <= w_src_a_nxt;
      r_src_b <= w_src_b_nxt;
      r_len   <= w_len_nxt;
      r_dst   <= w_dst_nxt;
    end
  end

`ifdef ACCEL_CSR_IRQ_EN
  // interrupt enable and level interrupt tracking DONE/ERROR
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ie <= 1'b0;
      irq  <= 1'b0;
    end else begin
      r_ie <= w_ie_nxt;
      irq  <= w_ie_nxt & (w_done_nxt | w_error_nxt);
    end
  end
`endif

  assign S_AWREADY = r_awready;
  assign S_WREADY  = r_wready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = r_arready;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;

endmodule
`default_nettype wire
